// File: rtl/band_mixer_pkg.sv
// Shared types and constants for the band mixer: FSM states, datapath widths
// and the Q2.14 unity gain.
package band_mixer_pkg;

   localparam int NBANDS    = 8;
   localparam int IDX_W     = $clog2(NBANDS);
   localparam int DATA_W    = 16;
   localparam int GAIN_W    = 16;
   localparam int PROD_W    = DATA_W + GAIN_W;
   localparam int ACC_W     = 35;
   localparam int FRAC_BITS = 14;

   localparam logic signed [GAIN_W-1:0] UNITY_GAIN = 16'sh4000;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_e;

endpackage

// File: rtl/band_mixer_if.sv
// Frame, gain-write and result signals of the band mixer.
// master drives bands and gain writes; slave is the mixer itself.
interface band_mixer_if;
   import band_mixer_pkg::*;

   logic signed [DATA_W-1:0] band0;
   logic signed [DATA_W-1:0] band1;
   logic signed [DATA_W-1:0] band2;
   logic signed [DATA_W-1:0] band3;
   logic signed [DATA_W-1:0] band4;
   logic signed [DATA_W-1:0] band5;
   logic signed [DATA_W-1:0] band6;
   logic signed [DATA_W-1:0] band7;
   logic                     bands_valid;
   logic                     gain_we;
   logic [IDX_W-1:0]         gain_addr;
   logic signed [GAIN_W-1:0] gain_wdata;
   logic signed [DATA_W-1:0] dataout;
   logic                     dout_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output band0, band1, band2, band3, band4, band5, band6, band7,
      output bands_valid, gain_we, gain_addr, gain_wdata,
      input  dataout, dout_valid, busy, overrun
   );

   modport slave (
      input  band0, band1, band2, band3, band4, band5, band6, band7,
      input  bands_valid, gain_we, gain_addr, gain_wdata,
      output dataout, dout_valid, busy, overrun
   );

endinterface

// File: rtl/band_mixer_sat.sv
// Round-half-up shift of the 35-bit accumulator down to a 16-bit sample.
// Clamping to the 16-bit range is built only when MIXER_SAT_EN is defined.
module band_mixer_sat
   import band_mixer_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [DATA_W-1:0] dout_o
);

   localparam int R_W = ACC_W - FRAC_BITS;
   localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (FRAC_BITS - 1));

   function automatic logic signed [R_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
      return R_W'((a + HALF_LSB) >>> FRAC_BITS);
   endfunction

`ifdef MIXER_SAT_EN
   localparam logic signed [R_W-1:0] R_MAX = R_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [R_W-1:0] R_MIN = R_W'(-(2 ** (DATA_W - 1)));

   function automatic logic signed [DATA_W-1:0] clamp(input logic signed [R_W-1:0] r);
      if (r > R_MAX)
         return {1'b0, {(DATA_W-1){1'b1}}};
      else if (r < R_MIN)
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return r[DATA_W-1:0];
   endfunction

   assign dout_o = clamp(round_shift(acc_i));
`else
   assign dout_o = DATA_W'(round_shift(acc_i));
`endif

endmodule

// File: rtl/band_mixer.sv
// Eight-band gain-and-sum mixer using one shared multiplier over eight cycles.
// Output saturation is selected at build time with MIXER_SAT_EN.
module band_mixer
   import band_mixer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   band_mixer_if.slave bus
);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] band_q [NBANDS];
   logic signed [DATA_W-1:0] band_d [NBANDS];
   logic signed [GAIN_W-1:0] pend_q [NBANDS];
   logic signed [GAIN_W-1:0] pend_d [NBANDS];
   logic signed [GAIN_W-1:0] act_q  [NBANDS];
   logic signed [GAIN_W-1:0] act_d  [NBANDS];
   logic signed [DATA_W-1:0] dataout_q, dataout_d;
   logic                     dout_valid_q, dout_valid_d;
   logic                     busy_q, busy_d;
   logic                     overrun_q, overrun_d;

   logic signed [DATA_W-1:0] band_in [NBANDS];
   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] mixed;

   assign band_in[0] = bus.band0;
   assign band_in[1] = bus.band1;
   assign band_in[2] = bus.band2;
   assign band_in[3] = bus.band3;
   assign band_in[4] = bus.band4;
   assign band_in[5] = bus.band5;
   assign band_in[6] = bus.band6;
   assign band_in[7] = bus.band7;

   assign prod = band_q[idx_q] * act_q[idx_q];

   band_mixer_sat u_sat (
      .acc_i  (acc_q),
      .dout_o (mixed)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      band_d       = band_q;
      pend_d       = pend_q;
      act_d        = act_q;
      dataout_d    = dataout_q;
      dout_valid_d = 1'b0;
      overrun_d    = bus.bands_valid && (state_q != IDLE);

      if (bus.gain_we)
         pend_d[bus.gain_addr] = bus.gain_wdata;

      case (state_q)
         IDLE: begin
            if (bus.bands_valid) begin
               // pend_d already carries a same-cycle gain write, so it is forwarded
               state_d = MAC;
               band_d  = band_in;
               act_d   = pend_d;
               acc_d   = '0;
               idx_d   = '0;
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NBANDS - 1))
               state_d = DONE;
         end
         DONE: begin
            state_d      = IDLE;
            dataout_d    = mixed;
            dout_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         acc_q        <= '0;
         pend_q       <= '{default: UNITY_GAIN};
         act_q        <= '{default: UNITY_GAIN};
         dataout_q    <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         pend_q       <= pend_d;
         act_q        <= act_d;
         dataout_q    <= dataout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   always_ff @(posedge clock) begin
      band_q <= band_d;
   end

   assign bus.dataout    = dataout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: doc/band_mixer.md
# band_mixer

Downstream stage of the FIR filter bank: captures the eight 16-bit band outputs when a frame is flagged valid, applies a programmable per-band gain, and sums the bands into one 16-bit mixed sample using a single shared multiplier over 8 cycles. Gains are double-buffered so a frame always uses one consistent gain set. Together with the filter bank, this forms the graphic-equalizer datapath.

## Interface
- NBANDS, 8, number of bands; fixed, not overridable
- DATA_W, 16, band and output sample width, signed
- GAIN_W, 16, gain width, signed Q2.14; unity is 0x4000
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- band0..band7  in  16  signed band samples from the filter bank
- bands_valid  in  1  one-cycle pulse; band0..7 are stable and are captured this cycle
- gain_we  in  1  gain write strobe
- gain_addr  in  3  band index for the gain write
- gain_wdata  in  16  signed Q2.14 gain value
- dataout  out  16  signed mixed sample
- dout_valid  out  1  one-cycle pulse; dataout is new this cycle
- busy  out  1  high while a frame is being processed
- overrun  out  1  one-cycle pulse; a bands_valid pulse was dropped

## Operation
- Gain storage:
  - pending[8] is written by gain_we at the clock edge.
  - active[8] is copied from pending when a frame is captured.
  - If gain_we and a capture happen in the same cycle, the written value is forwarded into active.
  - Both arrays reset to 0x4000.
- FSM states and transitions:
  - IDLE -> MAC on bands_valid. Capture band0..7, load active gains, clear the accumulator, idx=0.
  - MAC: acc += band[idx] * active[idx], then idx++. After the idx=7 accumulate, go to DONE.
  - DONE -> IDLE. Register dataout and pulse dout_valid.
- Arithmetic:
  - Each product is 32 bits signed. The accumulator is 35 bits signed, so it cannot overflow.
  - Result r = (acc + 2^13) >>> 14 (arithmetic shift, round half up), 21 bits.
  - Output formatting depends on the saturation option; see Configuration.
- Boundary conditions:
  - bands_valid while busy=1: ignored, the frame in flight is unaffected, and overrun pulses on the next cycle.
  - bands_valid in the same cycle that dout_valid is high: accepted, because the FSM is already in IDLE.
  - Reset mid-frame: the FSM returns to IDLE, the accumulator clears, and no dout_valid is produced for the aborted frame.

## Timing
- Reset values:
  - dataout = 0
  - dout_valid = 0, busy = 0, overrun = 0
  - FSM = IDLE, idx = 0, acc = 0
  - gains = 0x4000
- Latency: bands_valid sampled at edge E0 -> MAC accumulates on E1..E8 -> dout_valid is high in the cycle after E9. That is 10 clocks from the bands_valid cycle to the dout_valid cycle.
- busy is high from the cycle after E0 through the cycle before dout_valid.
- Throughput: one frame per 10 clocks.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- MIXER_SAT_EN defined: r is clamped to [-32768, 32767] before output.
- MIXER_SAT_EN undefined: dataout = r[15:0] (two's-complement wrap) and the saturation logic is not built.

## Structure
- Shared package band_mixer_pkg contains:
  - the state enum (IDLE, MAC, DONE)
  - DATA_W, GAIN_W, ACC_W=35, FRAC_BITS=14
  - UNITY_GAIN=16'h4000
- One sub-module, band_mixer_sat: combinational round/shift/clamp from 35 to 16 bits. The clamp is present only under MIXER_SAT_EN.

## Test plan
- Reset, default gains, all bands=100, bands_valid pulse -> dataout=800, dout_valid exactly 10 clocks later, busy high for the 9 cycles in between.
- Gains 0 except gain3=0x2000 -> band3=1000 gives 500. Rounding: band3=1 gives 1; band3=-1 gives 0.
- All bands=32767 at unity -> 32767 with MIXER_SAT_EN, 0xFFF8 (-8) without. All bands=-32768 -> -32768 with MIXER_SAT_EN, 0x0000 without.
- bands_valid at T and again at T+3 -> a single dout_valid at T+10 and an overrun pulse at T+4. A pulse at T+10 is accepted, giving dout_valid at T+20.
- Write gain0=0 during MAC -> the current frame still uses 0x4000; the next frame excludes band0. A write in the same cycle as bands_valid applies to that frame.
- Reset asserted at frame cycle 5 -> no dout_valid; all outputs return to reset values; the next frame is processed normally.
